// File: rtl/pe_row_sequencer.sv
// Command sequencer for one row of MAC tiles: turns LOAD/EXEC/SHIFT/CLEAR
// commands into registered inst_e/out_e beats for the row's first tile.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_len[7:0] : command handshake
//   din_valid/din_ready, din[bw-1:0]               : data beat handshake
//   inst_e[2:0], out_e[bw-1:0]                     : registered tile drive
//   done, err                                      : completion pulse
//
// Option: define PE_SEQ_FLUSH_EN to append col idle cycles after the last
// beat before done.
module pe_row_sequencer #(
  parameter int bw  = 4,
  parameter int col = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_len,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [bw-1:0] din,
  output logic [2:0]    inst_e,
  output logic [bw-1:0] out_e,
  output logic          done,
  output logic          err
);

  localparam int CW =
    ($clog2(col + 1) > 8) ? $clog2(col + 1) : 8;

  localparam logic [2:0] OP_LOAD_W  = 3'b000;
  localparam logic [2:0] OP_EXEC_W  = 3'b001;
  localparam logic [2:0] OP_EXEC_O  = 3'b010;
  localparam logic [2:0] OP_SHIFT_O = 3'b011;
  localparam logic [2:0] OP_CLEAR   = 3'b100;

  localparam logic [2:0] T_W_IDLE  = 3'b000;
  localparam logic [2:0] T_W_LOAD  = 3'b001;
  localparam logic [2:0] T_W_EXEC  = 3'b010;
  localparam logic [2:0] T_IDLE    = 3'b100;
  localparam logic [2:0] T_O_SHIFT = 3'b101;
  localparam logic [2:0] T_O_EXEC  = 3'b110;
  localparam logic [2:0] T_RESET   = 3'b111;

  localparam logic M_WS = 1'b0;
  localparam logic M_OS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WEXEC,
    S_OEXEC,
    S_OSHIFT,
    S_CLR,
    S_FLUSH,
    S_DONE
  } state_t;

`ifdef PE_SEQ_FLUSH_EN
  localparam state_t S_TAIL = S_FLUSH;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_mode;
  logic            w_mode_nxt;
  logic            r_err;
  logic [CW-1:0]   r_len;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_target;
  logic            w_more;
  logic [2:0]      r_inst;
  logic [2:0]      w_inst_nxt;
  logic [bw-1:0]   r_out;
  logic [bw-1:0]   w_out_nxt;
  logic [2:0]      w_idle;
  logic            w_accept;
  logic            w_legal;
  logic            w_op_ld;
  logic            w_op_ew;
  logic            w_op_eo;
  logic            w_op_sh;
  logic            w_op_cl;
  logic            w_len_z;

  assign w_accept = cmd_valid & (r_state == S_IDLE);
  assign w_op_ld  = (cmd_op == OP_LOAD_W);
  assign w_op_ew  = (cmd_op == OP_EXEC_W);
  assign w_op_eo  = (cmd_op == OP_EXEC_O);
  assign w_op_sh  = (cmd_op == OP_SHIFT_O);
  assign w_op_cl  = (cmd_op == OP_CLEAR);
  assign w_legal  = w_op_ld | w_op_ew | w_op_eo
                  | w_op_sh | w_op_cl;
  assign w_len_z  = (cmd_len == 8'd0);

  // The idle code follows the mode the accepted op
  // selects, so the first cycle after accept already
  // idles in the new mode.
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_accept && w_legal)
      w_mode_nxt = (w_op_ld | w_op_ew) ? M_WS : M_OS;
  end

  assign w_idle = (w_mode_nxt == M_OS) ? T_IDLE : T_W_IDLE;

  // LOAD always fills the whole row; CLR is one beat.
  always_comb begin
    w_target = r_len;
    if (r_state == S_LOAD)
      w_target = CW'(col);
    else if (r_state == S_CLR)
      w_target = CW'(1);
  end

  assign w_more = (r_cnt < w_target);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inst_nxt  = w_idle;
    w_out_nxt   = r_out;
    cmd_ready   = 1'b0;
    din_ready   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cnt_nxt = '0;
          unique case (1'b1)
            w_op_ld: w_state_nxt = S_LOAD;
            w_op_ew: w_state_nxt =
              w_len_z ? S_TAIL : S_WEXEC;
            w_op_eo: w_state_nxt =
              w_len_z ? S_TAIL : S_OEXEC;
            w_op_sh: w_state_nxt =
              w_len_z ? S_TAIL : S_OSHIFT;
            w_op_cl: w_state_nxt = S_CLR;
            default: w_state_nxt = S_DONE;
          endcase
        end
      end
      S_LOAD, S_WEXEC, S_OEXEC: begin
        if (w_more) begin
          din_ready = 1'b1;
          if (din_valid) begin
            unique case (r_state)
              S_LOAD:  w_inst_nxt = T_W_LOAD;
              S_WEXEC: w_inst_nxt = T_W_EXEC;
              default: w_inst_nxt = T_O_EXEC;
            endcase
            w_out_nxt = din;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          // Last beat is on the outputs this cycle.
          w_state_nxt = S_TAIL;
          w_cnt_nxt   = '0;
        end
      end
      S_OSHIFT, S_CLR: begin
        if (w_more) begin
          w_inst_nxt = (r_state == S_CLR) ?
                       T_RESET : T_O_SHIFT;
          w_out_nxt  = '0;
          w_cnt_nxt  = r_cnt + CW'(1);
        end else begin
          w_state_nxt = S_TAIL;
          w_cnt_nxt   = '0;
        end
      end
      S_FLUSH: begin
        if (r_cnt == CW'(col - 1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= M_WS;
      r_err   <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_inst  <= T_W_IDLE;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_inst  <= w_inst_nxt;
      r_out   <= w_out_nxt;
      if (w_accept) begin
        r_err <= ~w_legal;
        r_len <= CW'(cmd_len);
      end
    end
  end

  assign inst_e = r_inst;
  assign out_e  = r_out;
  assign done   = (r_state == S_DONE);
  assign err    = done & r_err;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Directed self-checking bench for pe_row_sequencer.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_pe_row_sequencer;

`ifdef PE_SEQ_FLUSH_EN
  localparam int FL = 8;
`else
  localparam int FL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_len;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] din;
  logic [2:0] inst_e;
  logic [3:0] out_e;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_err = 0;
  int consumed = 0;

  pe_row_sequencer #(.bw(4), .col(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .inst_e    (inst_e),
    .out_e     (out_e),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op,
                          input logic [7:0] len);
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input string tag,
                      input logic [3:0] d,
                      input logic [2:0] ei);
    chk({tag, "_rdy"}, din_ready, 1);
    din_valid = 1'b1;
    din       = d;
    if (din_ready) consumed++;
    step();
    din_valid = 1'b0;
    chk({tag, "_inst"}, inst_e, ei);
    chk({tag, "_out"}, out_e, d);
  endtask

  task automatic finish_cmd(input string tag,
                            input int nfl,
                            input logic [2:0] idle,
                            input logic e);
    for (int k = 0; k < nfl; k++) begin
      chk({tag, "_fl_done"}, done, 0);
      chk({tag, "_fl_inst"}, inst_e, idle);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, e);
    chk({tag, "_dn_inst"}, inst_e, idle);
    chk({tag, "_dn_crdy"}, cmd_ready, 0);
    step();
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_crdy"}, cmd_ready, 1);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_len   = 8'd0;
    din_valid = 1'b0;
    din       = 4'd0;
    step();
    step();
    chk("rst_inst", inst_e, 3'b000);
    chk("rst_out", out_e, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_drdy", din_ready, 0);
    chk("rst_crdy", cmd_ready, 1);
    reset = 1'b1;
    step();

    // LOAD_W: 8 beats of 001, data in column order
    send_cmd(3'b000, 8'd0);
    for (int i = 1; i <= 8; i++)
      beat("ld", 4'(i), 3'b001);
    chk("ld_drdy_end", din_ready, 0);
    step();
    finish_cmd("ld", FL, 3'b000, 1'b0);

    // EXEC_W len=4 with a bubble on the 2nd offer
    consumed = 0;
    send_cmd(3'b001, 8'd4);
    beat("ew1", 4'hA, 3'b010);
    chk("ew_bub_rdy", din_ready, 1);
    step();
    chk("ew_bub_inst", inst_e, 3'b000);
    chk("ew_bub_out", out_e, 4'hA);
    beat("ew2", 4'hB, 3'b010);
    beat("ew3", 4'hC, 3'b010);
    beat("ew4", 4'hD, 3'b010);
    chk("ew_drdy_end", din_ready, 0);
    chk("ew_consumed", consumed, 4);
    step();
    finish_cmd("ew", FL, 3'b000, 1'b0);

    // EXEC_O len=3 then SHIFT_O len=8
    send_cmd(3'b010, 8'd3);
    beat("eo1", 4'h5, 3'b110);
    beat("eo2", 4'h6, 3'b110);
    beat("eo3", 4'h7, 3'b110);
    step();
    finish_cmd("eo", FL, 3'b100, 1'b0);
    send_cmd(3'b011, 8'd8);
    for (int i = 0; i < 8; i++) begin
      chk("sh_drdy", din_ready, 0);
      step();
      chk("sh_inst", inst_e, 3'b101);
      chk("sh_out", out_e, 0);
    end
    step();
    finish_cmd("sh", FL, 3'b100, 1'b0);

    // CLEAR: single 111 beat
    send_cmd(3'b100, 8'd9);
    step();
    chk("cl_inst", inst_e, 3'b111);
    chk("cl_out", out_e, 0);
    step();
    finish_cmd("cl", FL, 3'b100, 1'b0);

    // Illegal op: no beats, mode stays OS
    send_cmd(3'b110, 8'd3);
    finish_cmd("ill", 0, 3'b100, 1'b1);

    // EXEC_W len=0: no beats, mode becomes WS
    send_cmd(3'b001, 8'd0);
    finish_cmd("ew0", FL, 3'b000, 1'b0);

    // Reset in the middle of EXEC_O beat 2 of 5
    send_cmd(3'b010, 8'd5);
    beat("rs1", 4'h3, 3'b110);
    din_valid = 1'b1;
    din       = 4'h4;
    reset     = 1'b0;
    #1;
    chk("rs_async_inst", inst_e, 3'b000);
    step();
    chk("rs_inst", inst_e, 3'b000);
    chk("rs_out", out_e, 0);
    chk("rs_crdy", cmd_ready, 1);
    chk("rs_drdy", din_ready, 0);
    chk("rs_done", done, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rs_post_inst", inst_e, 3'b000);
      chk("rs_post_drdy", din_ready, 0);
      chk("rs_post_done", done, 0);
    end
    din_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_row_sequencer.md
PE_ROW_SEQUENCER -- requirements
Module: pe_row_sequencer

Interface
REQ-001 SHALL have parameter bw, default 4: activation/weight width per beat.
REQ-002 SHALL have parameter col, default 8: number of MAC tiles in the driven row.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1: a command can be accepted.
REQ-007 SHALL have port cmd_op, input, 3: 000 LOAD_W, 001 EXEC_W, 010 EXEC_O, 011 SHIFT_O, 100 CLEAR, 101-111 illegal.
REQ-008 SHALL have port cmd_len, input, 8: beat count for EXEC_W, EXEC_O and SHIFT_O.
REQ-009 SHALL have port din_valid, input, 1: a data beat is offered.
REQ-010 SHALL have port din_ready, output, 1: the data beat can be consumed.
REQ-011 SHALL have port din, input, bw: the weight or activation beat.
REQ-012 SHALL have port inst_e, output, 3: instruction to the row's first tile (inst_w).
REQ-013 SHALL have port out_e, output, bw: data to the row's first tile (in_w).
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a command completes.
REQ-015 SHALL have port err, output, 1: valid with done; high only for an illegal op.

Function
REQ-016 SHALL use tile encodings: W_IDLE 000, W_LOAD 001, W_EXEC 010, IDLE 100, O_SHIFT 101, O_EXEC 110, RESET 111.
REQ-017 SHALL implement states IDLE, LOAD, WEXEC, OEXEC, OSHIFT, CLR, FLUSH, DONE.
REQ-018 SHALL drive cmd_ready high only in IDLE; a command is accepted on cmd_valid & cmd_ready, with op and len captured.
REQ-019 SHALL hold a mode register set by the last accepted op: WS for LOAD_W/EXEC_W, OS for EXEC_O/SHIFT_O/CLEAR; the reset value is WS.
REQ-020 SHALL drive the idle instruction as 000 when the mode is WS and 100 when the mode is OS, in every non-issuing cycle.
REQ-021 SHALL register inst_e and out_e: a beat accepted in cycle t appears at the outputs in cycle t+1.
REQ-022 SHALL, in LOAD, issue exactly col beats of 001 with out_e=din, in column order 0..col-1, ignoring cmd_len.
REQ-023 SHALL, in WEXEC, issue cmd_len beats of 010 with out_e=din.
REQ-024 SHALL, in OEXEC, issue cmd_len beats of 110 with out_e=din.
REQ-025 SHALL drive din_ready high only in LOAD/WEXEC/OEXEC while beats remain.
REQ-026 SHALL, when din_valid is low in a data state, emit the mode idle instruction with out_e held; the beat counter does not advance (bubble).
REQ-027 SHALL, in OSHIFT, issue cmd_len back-to-back beats of 101 with out_e=0 and consume no din.
REQ-028 SHALL, in CLR, issue a single beat of 111 with out_e=0.
REQ-029 SHALL, for cmd_len=0 on EXEC_W/EXEC_O/SHIFT_O, issue no beats and go straight to FLUSH/DONE.
REQ-030 SHALL accept an illegal op, issue nothing, change no mode, and pulse done with err=1.
REQ-031 SHALL pulse done in the cycle after the final issued beat (or after the final flush cycle), then return to IDLE; a command is accepted no earlier than the cycle after done.

Reset
REQ-032 SHALL, on reset low at any time including mid-command, immediately return to IDLE with mode WS, inst_e=000, out_e=0, done=0, err=0, din_ready=0, cmd_ready=1 and all counters cleared.
REQ-033 SHALL NOT issue a partial command after reset release; the aborted command is dropped.

Configuration
REQ-034 SHALL support the macro PE_SEQ_FLUSH_EN.
REQ-035 SHALL, when PE_SEQ_FLUSH_EN is defined, enter FLUSH after the last beat, emit col cycles of the mode idle instruction, then pulse done.
REQ-036 SHALL, when PE_SEQ_FLUSH_EN is undefined, omit FLUSH and pulse done immediately after the last beat.

Verification
REQ-037 LOAD_W, din 1..8 always valid -> inst_e=001 for 8 cycles, out_e=1..8 in order, then done (flush off).
REQ-038 EXEC_W len=4, din_valid low on the 2nd offer -> inst_e sequence 010,000,010,010,010 and exactly 4 beats consumed.
REQ-039 EXEC_O len=3 then SHIFT_O len=8 -> 110 x3, then 101 x8 with out_e=0; idle afterwards = 100.
REQ-040 CLEAR with PE_SEQ_FLUSH_EN -> one 111 beat, 8 cycles of 100, then done.
REQ-041 cmd_op=110 -> no beats, done=1 and err=1 together; EXEC_W len=0 -> done with err=0.
REQ-042 reset low during EXEC_O beat 2 of 5 -> next cycle inst_e=000, out_e=0, cmd_ready=1; no further beats issued.
